// File: rtl/codec_ctrl_responder.sv
// rtl/codec_ctrl_responder.sv - codec 3-wire control port responder with shadow register map
module codec_ctrl_responder #(
    parameter int NUM_BITS = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       spi_sck,
    input  logic       spi_mosi,
    input  logic       cs,
    input  logic [3:0] rd_addr,
    output logic [8:0] rd_data,
    output logic       wr_strobe,
    output logic [6:0] wr_addr,
    output logic [8:0] wr_data,
    output logic       frame_err,
    output logic       addr_err,
    output logic       active,
    output logic [7:0] pd,
    output logic [1:0] iwl,
    output logic [1:0] fmt,
    output logic       ms
);

    localparam logic [4:0] FRAME_LEN = 5'(NUM_BITS);

    logic [2:0]  sck_q;
    logic [1:0]  mosi_q;
    logic [2:0]  cs_q;
    logic [15:0] shift_q;
    logic [4:0]  bitcnt;
    logic [8:0]  regs     [0:9];
    logic [8:0]  regs_nxt [0:9];

    logic        sck_rise;
    logic        cs_rise;
    logic [15:0] shift_nxt;
    logic [4:0]  cnt_inc;
    logic [4:0]  cnt_nxt;
    logic        commit;
    logic        ferr_nxt;
    logic        aerr_nxt;
    logic [6:0]  frame_addr;
    logic [8:0]  frame_data;

    function automatic logic [8:0] reg_default(input int idx);
        case (idx)
            0, 1:    reg_default = 9'h097;
            2, 3:    reg_default = 9'h079;
            4:       reg_default = 9'h00A;
            5:       reg_default = 9'h008;
            6:       reg_default = 9'h09F;
            7:       reg_default = 9'h00A;
            default: reg_default = 9'h000;
        endcase
    endfunction

    assign sck_rise   = sck_q[1] & ~sck_q[2];
    assign cs_rise    = cs_q[1] & ~cs_q[2];
    assign frame_addr = shift_nxt[15:9];
    assign frame_data = shift_nxt[8:0];

    // The shift is resolved first so a coincident CS rise sees the updated count.
    always_comb begin
        shift_nxt = shift_q;
        cnt_inc   = bitcnt;
        if (sck_rise && cs_q[1]) begin
            shift_nxt = {shift_q[14:0], mosi_q[1]};
            cnt_inc   = (bitcnt == 5'd31) ? bitcnt : bitcnt + 5'd1;
        end
        cnt_nxt  = cnt_inc;
        commit   = 1'b0;
        ferr_nxt = 1'b0;
        if (cs_rise) begin
            cnt_nxt = 5'd0;
            if (cnt_inc == FRAME_LEN) begin
                commit = 1'b1;
            end else begin
                ferr_nxt = 1'b1;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < 10; i++) begin
            regs_nxt[i] = regs[i];
        end
        aerr_nxt = 1'b0;
        if (commit) begin
            case (frame_addr)
                7'h00, 7'h02: begin
                    regs_nxt[frame_addr[1:0]] = frame_data;
                    if (frame_data[8]) regs_nxt[frame_addr[1:0] + 2'd1] = frame_data;
                end
                7'h01, 7'h03: begin
                    regs_nxt[frame_addr[1:0]] = frame_data;
                    if (frame_data[8]) regs_nxt[frame_addr[1:0] - 2'd1] = frame_data;
                end
                7'h04, 7'h05, 7'h06, 7'h07, 7'h08, 7'h09: begin
                    for (int i = 4; i < 10; i++) begin
                        if (int'(frame_addr) == i) regs_nxt[i] = frame_data;
                    end
                end
                7'h0F: begin
                    for (int i = 0; i < 10; i++) begin
                        regs_nxt[i] = reg_default(i);
                    end
                end
                default: aerr_nxt = 1'b1;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sck_q     <= 3'b000;
            mosi_q    <= 2'b00;
            cs_q      <= 3'b111;
            shift_q   <= 16'h0000;
            bitcnt    <= 5'd0;
            wr_strobe <= 1'b0;
            frame_err <= 1'b0;
            addr_err  <= 1'b0;
            wr_addr   <= 7'h00;
            wr_data   <= 9'h000;
            for (int i = 0; i < 10; i++) begin
                regs[i] <= reg_default(i);
            end
        end else begin
            sck_q     <= {sck_q[1:0], spi_sck};
            mosi_q    <= {mosi_q[0], spi_mosi};
            cs_q      <= {cs_q[1:0], cs};
            shift_q   <= shift_nxt;
            bitcnt    <= cnt_nxt;
            wr_strobe <= commit;
            frame_err <= ferr_nxt;
            addr_err  <= aerr_nxt;
            if (commit) begin
                wr_addr <= frame_addr;
                wr_data <= frame_data;
            end
            for (int i = 0; i < 10; i++) begin
                regs[i] <= regs_nxt[i];
            end
        end
    end

    assign rd_data = (rd_addr <= 4'd9) ? regs[rd_addr] : 9'h000;
    assign active  = regs[9][0];
    assign pd      = regs[6][7:0];
    assign iwl     = regs[7][3:2];
    assign fmt     = regs[7][1:0];
    assign ms      = regs[7][6];

endmodule

// File: tb/tb_codec_ctrl_responder.sv
// tb/tb_codec_ctrl_responder.sv - randomized self-checking bench for codec_ctrl_responder
module tb_codec_ctrl_responder;

    logic       clk = 1'b0;
    logic       reset;
    logic       spi_sck;
    logic       spi_mosi;
    logic       cs;
    logic [3:0] rd_addr;
    logic [8:0] rd_data;
    logic       wr_strobe;
    logic [6:0] wr_addr;
    logic [8:0] wr_data;
    logic       frame_err;
    logic       addr_err;
    logic       active;
    logic [7:0] pd;
    logic [1:0] iwl;
    logic [1:0] fmt;
    logic       ms;

    codec_ctrl_responder #(.NUM_BITS(16)) dut (
        .clk(clk), .reset(reset), .spi_sck(spi_sck), .spi_mosi(spi_mosi), .cs(cs),
        .rd_addr(rd_addr), .rd_data(rd_data), .wr_strobe(wr_strobe), .wr_addr(wr_addr),
        .wr_data(wr_data), .frame_err(frame_err), .addr_err(addr_err), .active(active),
        .pd(pd), .iwl(iwl), .fmt(fmt), .ms(ms)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int strobe_cnt, ferr_cnt, aerr_cnt, aerr_lone;

    logic [8:0] mregs [0:9];
    logic [6:0] m_wa;
    logic [8:0] m_wd;
    int         exp_aerr;

    function automatic logic [8:0] dflt(input int i);
        logic [8:0] tbl [0:9];
        tbl = '{9'h097, 9'h097, 9'h079, 9'h079, 9'h00A, 9'h008, 9'h09F, 9'h00A, 9'h000, 9'h000};
        return tbl[i];
    endfunction

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            if (wr_strobe) strobe_cnt++;
            if (frame_err) ferr_cnt++;
            if (addr_err) aerr_cnt++;
            if (addr_err && !wr_strobe) aerr_lone++;
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 10; i++) mregs[i] = dflt(i);
        m_wa = 7'h00;
        m_wd = 9'h000;
    endtask

    task automatic model_commit(input logic [6:0] a, input logic [8:0] d);
        m_wa = a;
        m_wd = d;
        if (a <= 7'h03) begin
            mregs[a] = d;
            if (d[8]) mregs[a ^ 7'h01] = d;
        end else if (a <= 7'h09) begin
            mregs[a] = d;
        end else if (a == 7'h0F) begin
            for (int i = 0; i < 10; i++) mregs[i] = dflt(i);
        end else begin
            exp_aerr = 1;
        end
    endtask

    task automatic check_all(input string tag);
        for (int i = 0; i < 16; i++) begin
            rd_addr = 4'(i);
            #1;
            check($sformatf("%s rd%0d", tag, i), rd_data, (i < 10) ? mregs[i] : 0);
        end
        check({tag, " active"}, active, mregs[9][0]);
        check({tag, " pd"}, pd, mregs[6][7:0]);
        check({tag, " iwl"}, iwl, mregs[7][3:2]);
        check({tag, " fmt"}, fmt, mregs[7][1:0]);
        check({tag, " ms"}, ms, mregs[7][6]);
        check({tag, " wr_addr"}, wr_addr, m_wa);
        check({tag, " wr_data"}, wr_data, m_wd);
    endtask

    task automatic send_bit(input logic b);
        spi_mosi = b;
        tick(4);
        spi_sck = 1'b1;
        tick(4);
        spi_sck = 1'b0;
    endtask

    task automatic send_frame(input logic [15:0] w, input int n, input string tag);
        logic b;
        strobe_cnt = 0; ferr_cnt = 0; aerr_cnt = 0; aerr_lone = 0;
        exp_aerr = 0;
        for (int k = n - 1; k >= 0; k--) begin
            b = (k < 16) ? w[k] : 1'($urandom);
            send_bit(b);
        end
        tick(4);
        cs = 1'b0;
        tick(4);
        cs = 1'b1;
        tick(8);
        if (n == 16) model_commit(w[15:9], w[8:0]);
        check({tag, " strobes"}, strobe_cnt, (n == 16) ? 1 : 0);
        check({tag, " frame_err"}, ferr_cnt, (n == 16) ? 0 : 1);
        check({tag, " addr_err"}, aerr_cnt, exp_aerr);
        check({tag, " addr_err_alone"}, aerr_lone, 0);
        check_all(tag);
    endtask

    task automatic wr(input logic [6:0] a, input logic [8:0] d, input string tag);
        send_frame({a, d}, 16, tag);
    endtask

    initial begin
        logic [6:0] a;
        int         sel;
        int         n;
        reset = 1'b1; spi_sck = 1'b0; spi_mosi = 1'b0; cs = 1'b1; rd_addr = 4'h0;
        strobe_cnt = 0; ferr_cnt = 0; aerr_cnt = 0; aerr_lone = 0;
        model_reset();
        tick(3);
        check("reset strobe", wr_strobe, 0);
        check("reset frame_err", frame_err, 0);
        check("reset addr_err", addr_err, 0);
        reset = 1'b0;
        tick(2);
        check_all("reset");
        check("reset pd const", pd, 8'h9F);

        wr(7'h06, 9'h010, "single");
        check("single pd const", pd, 8'h10);
        wr(7'h00, 9'h11F, "link0");
        check("link0 r1 const", mregs[1] == 9'h11F ? rd_data : 0, 0);
        wr(7'h02, 9'h07C, "link2");
        send_frame({7'h05, 9'h1AB}, 15, "short15");
        send_frame({7'h05, 9'h1AB}, 17, "long17");
        wr(7'h0A, 9'h055, "unmapped");

        wr(7'h06, 9'h000, "cfg r6a");
        wr(7'h06, 9'h010, "cfg r6b");
        wr(7'h00, 9'h11F, "cfg r0");
        wr(7'h02, 9'h17C, "cfg r2");
        wr(7'h04, 9'h012, "cfg r4");
        wr(7'h05, 9'h001, "cfg r5");
        wr(7'h07, 9'h05B, "cfg r7");
        wr(7'h08, 9'h000, "cfg r8");
        wr(7'h09, 9'h001, "cfg r9");
        wr(7'h06, 9'h000, "cfg r6c");
        check("cfg active const", active, 1);
        check("cfg ms const", ms, 1);
        check("cfg iwl const", iwl, 2'b10);
        check("cfg fmt const", fmt, 2'b11);
        wr(7'h0F, 9'h1FF, "cfg reset word");
        check("cfg pd default", pd, 8'h9F);

        for (int k = 0; k < 8; k++) send_bit(1'($urandom));
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        model_reset();
        tick(2);
        wr(7'h09, 9'h001, "midreset");
        check("midreset active const", active, 1);

        for (int it = 0; it < 40; it++) begin
            sel = $urandom_range(0, 7);
            if (sel <= 5) a = 7'($urandom_range(0, 9));
            else if (sel == 6) a = 7'h0F;
            else a = 7'($urandom);
            n = ($urandom_range(0, 5) == 0) ? $urandom_range(1, 20) : 16;
            send_frame({a, 9'($urandom)}, n, $sformatf("rnd%0d", it));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/codec_ctrl_responder.md
# codec_ctrl_responder

Synthesizable responder for the codec's 3-wire control port: receives 16-bit words {7-bit address, 9-bit data} MSB-first on `spi_sck`/`spi_mosi` and commits each word on the rising edge of `cs`. It holds a shadow copy of the codec register map with power-on defaults and exposes decoded fields. It sits opposite the codec configurator, on-chip for loopback self-check and in benches as a codec control-port model.

## Interface
- `NUM_BITS`, 16: frame length in SCK rising edges; a frame commits only at exactly this count.
- `clk` input 1: system clock; all logic on its rising edge.
- `reset` input 1: asynchronous, active-high; clears all state and loads register defaults.
- `spi_sck` input 1: serial clock from initiator; asynchronous to `clk`.
- `spi_mosi` input 1: serial data, sampled on SCK rising edge.
- `cs` input 1: idle high; a low pulse followed by a rising edge latches the frame.
- `rd_addr` input 4: shadow register select, 0x0–0x9.
- `rd_data` output 9: combinational read of `regs[rd_addr]`; 0 for `rd_addr` > 9.
- `wr_strobe` output 1: one-cycle pulse per committed frame.
- `wr_addr` output 7: address of the last committed frame; held between strobes.
- `wr_data` output 9: data of the last committed frame; held between strobes.
- `frame_err` output 1: one-cycle pulse when the bit count at CS rising is not `NUM_BITS`.
- `addr_err` output 1: one-cycle pulse, coincident with `wr_strobe`, for an unmapped address.
- `active` output 1: R9[0].
- `pd` output 8: R6[7:0] power-down bits.
- `iwl` output 2: R7[3:2].
- `fmt` output 2: R7[1:0].
- `ms` output 1: R7[6].

## Operation
- Input synchronizers:
  - `spi_sck`, `spi_mosi`, `cs` each pass through a 2-FF synchronizer, plus a third history FF on `spi_sck` and `cs` for edge detection.
  - All decisions use the synchronized values.
- Shifting:
  - On each detected SCK rise while synchronized `cs` = 1, shift `mosi` into a 16-bit shift register LSB end and increment `bitcnt`.
  - `bitcnt` is 5 bits and saturates at 31.
  - SCK rises while `cs` = 0 are ignored.
- Latching, on a detected CS rise:
  - `bitcnt == NUM_BITS`: commit. Set `wr_addr` = shift[15:9] and `wr_data` = shift[8:0], and pulse `wr_strobe`.
  - Otherwise: pulse `frame_err` with no register change.
  - In either case, clear `bitcnt` in the same cycle.
- Commit actions by address:
  - 0x00: R0 ← data. If data[8] is set, R1 ← data as well.
  - 0x01: R1 ← data. If data[8] is set, R0 ← data as well.
  - 0x02/0x03: same linkage as 0x00/0x01, applied to R2/R3.
  - 0x04–0x09: Rn ← data.
  - 0x0F: all R0–R9 ← defaults; data is ignored.
  - Any other address: no change; pulse `addr_err`.
- Register defaults: R0 0x097, R1 0x097, R2 0x079, R3 0x079, R4 0x00A, R5 0x008, R6 0x09F, R7 0x00A, R8 0x000, R9 0x000.
- States (informal): IDLE/SHIFT, tracked by `bitcnt`. No handshake back to the initiator; the responder is always ready.

## Timing
- Reset values:
  - `wr_strobe`, `frame_err`, `addr_err` = 0.
  - `wr_addr` = 0, `wr_data` = 0.
  - Shift register 0, `bitcnt` 0, synchronizer FFs 0 except `cs` stages = 1.
  - `regs` = defaults, so `active` = 0, `pd` = 0x9F, `iwl` = 2'b10, `fmt` = 2'b10, `ms` = 0.
- Latency:
  - CS pin rise to `wr_strobe`/`frame_err` high: the 3rd `clk` rising edge after the pin change is captured.
  - `regs` and all decoded outputs update on that same edge.
- Strobe width: `wr_strobe`, `frame_err` and `addr_err` are exactly 1 cycle wide.
- Minimum input timing: SCK high/low and CS low each ≥ 3 `clk` periods. Faster input is undefined.
- SCK rise and CS rise detected in the same cycle: the shift takes effect first, then the latch evaluates the incremented count.
- Back-to-back frames: shifting resumes on the first SCK rise after the CS rise; no dead cycles are required.
- Reset asserted mid-frame: the partial frame is discarded immediately. After release, the next complete 16-bit frame commits normally.

## Test plan
- Reset check: assert `reset` → `rd_data` for addresses 0–9 matches the defaults; `pd` = 0x9F, `active` = 0, all pulses low.
- Single write: shift 0x0C10 (addr 0x06, data 0x010), then CS low/high → one `wr_strobe`, `wr_addr` = 0x06, `wr_data` = 0x010, `pd` = 0x10, `addr_err` = 0.
- Linked write: frame addr 0x00, data 0x11F → R0 = R1 = 0x11F. Then frame addr 0x02, data 0x07C (bit8 clear) → R2 = 0x07C, R3 = 0x079.
- Error frames:
  - 15 bits then CS rise → `frame_err` pulse, no strobe, registers unchanged.
  - 17 bits → same result.
  - Address 0x0A → `wr_strobe` and `addr_err` both pulse, no register change.
- Full configuration sequence: send R6 0x000, R6 0x010, R0 0x11F, R2 0x17C, R4 0x012, R5 0x001, R7 0x05B, R8 0x000, R9 0x001, R6 0x000, then 0x0F → before the 0x0F word: `active` = 1, `ms` = 1, `iwl` = 2'b10, `fmt` = 2'b11; after it: all defaults restored.
- Mid-frame reset: shift 8 bits, pulse `reset`, then send a full frame for addr 0x09, data 0x001 → `active` = 1, with exactly one `wr_strobe` after reset.
